// File: rtl/cache_pkg.sv
// Shared L1 cache geometry and miss-handling FSM state type.
package cache_pkg;

  localparam int unsigned TAG_W    = 27;
  localparam int unsigned SET_W    = 2;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned WAYS     = 2;
  localparam int unsigned SETS     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    L2_LOOK = 3'd2,
    MEM_RD  = 3'd3,
    REFILL  = 3'd4
  } miss_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/l1_miss_ctrl.sv
// L1 data-cache miss sequencer: dirty writeback, L2 lookup, memory read, refill.
module l1_miss_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  hitL1,
  input  logic                  victim_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [DATA_WIDTH-1:0] victim_data,
  output logic                  stall,
  output logic                  l2_req,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  input  logic                  hitL2,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  refill_en,
  output logic [ADDR_WIDTH-1:0] refill_addr,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  miss_state_t           state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  miss;

  // A miss is only accepted while idle; other states ignore the CPU side.
  assign miss  = (state == IDLE) & cpu_req & ~hitL1;
  assign stall = (state != IDLE) | miss;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss),
    .count (miss_count)
  );

  // State and registered outputs; outputs are loaded for the state being entered.
  // mem_addr/mem_wdata double as the victim latches during writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_addr    <= '0;
      l2_req      <= 1'b0;
      l2_addr     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      refill_en   <= 1'b0;
      refill_addr <= '0;
      refill_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_addr <= cpu_addr;
            if (victim_dirty) begin
              state     <= WB;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= victim_addr;
              mem_wdata <= victim_data;
            end else begin
              state   <= L2_LOOK;
              l2_req  <= 1'b1;
              l2_addr <= cpu_addr;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            state   <= L2_LOOK;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            l2_req  <= 1'b1;
            l2_addr <= lat_addr;
          end
        end
        L2_LOOK: begin
          l2_req <= 1'b0;
          if (hitL2) begin
            state       <= REFILL;
            refill_en   <= 1'b1;
            refill_addr <= lat_addr;
            refill_data <= l2_rdata;
          end else begin
            state    <= MEM_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= lat_addr;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            state       <= REFILL;
            mem_req     <= 1'b0;
            refill_en   <= 1'b1;
            refill_addr <= lat_addr;
            refill_data <= mem_rdata;
          end
        end
        REFILL: begin
          state     <= IDLE;
          refill_en <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          l2_req    <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          refill_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
